// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO feeding a baud-timed 8N1 serialiser.
// Define IO_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module io_uart_tx #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 867
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [3:0]        i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [DIV_W-1:0] CntOne = 1;

`ifdef IO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StParity} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e            state_q, state_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  frame_div_q, frame_div_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        sh_q, sh_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              empty, full, pop, push, push_req, cnt_zero;
    logic [7:0]        head;
`ifdef IO_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic unused_wdata;
    assign unused_wdata = ^i_wdata[DATA_W-1:DIV_W];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_zero = (cnt_q == '0);
    assign push_req = i_we && (i_addr == 4'h0);
    // A full FIFO still accepts a byte when the serialiser frees a slot on the same edge.
    assign push     = push_req && (!full || pop);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_div_d = frame_div_q;
        bit_idx_d   = bit_idx_q;
        sh_d        = sh_q;
        pop         = 1'b0;
`ifdef IO_UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            StIdle, StStop: begin
                if (state_q == StStop && !cnt_zero) begin
                    cnt_d = cnt_q - CntOne;
                end else if (!empty) begin
                    // New frame: divisor written since the last frame takes effect here.
                    pop         = 1'b1;
                    state_d     = StStart;
                    cnt_d       = div_q;
                    frame_div_d = div_q;
                    sh_d        = head;
`ifdef IO_UART_TX_PARITY_EN
                    par_d       = ^head;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StStart: begin
                if (cnt_zero) begin
                    state_d   = StData;
                    cnt_d     = frame_div_q;
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StData: begin
                if (cnt_zero) begin
                    cnt_d = frame_div_q;
                    if (bit_idx_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        sh_d      = {1'b0, sh_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
`ifdef IO_UART_TX_PARITY_EN
            StParity: begin
                if (cnt_zero) begin
                    state_d = StStop;
                    cnt_d   = frame_div_q;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Line level is a function of the state being entered so o_tx can be registered.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = sh_d[0];
`ifdef IO_UART_TX_PARITY_EN
            StParity: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        div_d = div_q;
        if (i_we && (i_addr == 4'h8)) begin
            div_d = i_wdata[DIV_W-1:0];
        end
        ovf_d = ovf_q;
        if (i_re && (i_addr == 4'h4)) begin
            ovf_d = 1'b0;
        end
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = '0;
            if (i_addr == 4'h4) begin
                rdata_d[3:0] = {ovf_q, state_q != StIdle, empty, full};
            end else if (i_addr == 4'h8) begin
                rdata_d[DIV_W-1:0] = div_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            div_q       <= DIV_W'(DEFAULT_DIV);
            cnt_q       <= '0;
            frame_div_q <= '0;
            bit_idx_q   <= '0;
            sh_q        <= '0;
            tx_q        <= 1'b1;
            ovf_q       <= 1'b0;
            rdata_q     <= '0;
`ifdef IO_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push ? wr_ptr_q + PtrOne : wr_ptr_q;
            rd_ptr_q    <= pop ? rd_ptr_q + PtrOne : rd_ptr_q;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            frame_div_q <= frame_div_d;
            bit_idx_q   <= bit_idx_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            ovf_q       <= ovf_d;
            rdata_q     <= rdata_d;
`ifdef IO_UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_wdata[7:0];
        end
    end

    assign o_tx    = tx_q;
    assign o_rdata = rdata_q;
    assign o_busy  = (state_q != StIdle);
    assign o_irq   = empty && (state_q == StIdle);

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx (default build, no parity): registers, framing, FIFO, reset.
module tb_io_uart_tx;

    localparam int LOG = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata;
    logic        tx, busy, irq;

    io_uart_tx dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_we   (we),
        .i_re   (re),
        .i_addr (addr),
        .i_wdata(wdata),
        .o_rdata(rdata),
        .o_tx   (tx),
        .o_busy (busy),
        .o_irq  (irq)
    );

    always #5 clk = ~clk;

    // cyc equals the number of the most recent rising edge when read on a falling edge.
    int cyc = 0;
    int busy_total = 0;
    bit txlog [LOG];
    bit busylog [LOG];
    bit irqlog [LOG];

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        busy_total <= busy_total + (busy ? 1 : 0);
    end

    always @(negedge clk) begin
        if (cyc < LOG) begin
            txlog[cyc]   <= tx;
            busylog[cyc] <= busy;
            irqlog[cyc]  <= irq;
        end
    end

    int n_checks = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; the access lands on the following rising edge.
    task automatic wr(input logic [3:0] a, input logic [63:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [63:0] d);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int start, input logic [7:0] b,
                               input int bl);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int n = 0; n < 10 * bl; n++) begin
            check($sformatf("%s tx[%0d]", tag, n), 64'(txlog[start + n]), 64'(fr[n / bl]));
            check($sformatf("%s busy[%0d]", tag, n), 64'(busylog[start + n]), 64'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int k;
        int bt;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst tx", 64'(tx), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst irq", 64'(irq), 64'd1);
        check("rst rdata", rdata, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rd(4'h8, d); check("rst div", d, 64'd867);
        rd(4'h4, d); check("rst status", d, 64'h2);
        rd(4'h0, d); check("txdata reads 0", d, 64'h0);

        // DIV=3, single frame 0xA5
        wr(4'h8, 64'd3);
        wr(4'h0, 64'hA5);
        k = cyc;
        wait_cyc(k + 42);
        check("a5 idle at write", 64'(txlog[k]), 64'd1);
        check_frame("a5", k + 1, 8'hA5, 4);
        check("a5 busy end", 64'(busylog[k + 41]), 64'd0);
        check("a5 irq end", 64'(irqlog[k + 41]), 64'd1);

        // DIV=0, two back-to-back frames
        wr(4'h8, 64'd0);
        we = 1'b1; addr = 4'h0; wdata = 64'h01;
        @(negedge clk);
        k = cyc;
        wdata = 64'h02;
        @(negedge clk);
        we = 1'b0;
        wait_cyc(k + 22);
        check_frame("b2b01", k + 1, 8'h01, 1);
        check_frame("b2b02", k + 11, 8'h02, 1);
        check("b2b irq in stop", 64'(irqlog[k + 20]), 64'd0);
        check("b2b irq end", 64'(irqlog[k + 21]), 64'd1);
        check("b2b busy end", 64'(busylog[k + 21]), 64'd0);

        // DIV=3, overflow: one frame in flight, nine more pushes, last one dropped
        wr(4'h8, 64'd3);
        wr(4'h0, 64'h11);
        k = cyc;
        bt = busy_total;
        we = 1'b1; addr = 4'h0;
        for (int i = 0; i < 9; i++) begin
            wdata = 64'h20 + 64'(i);
            @(negedge clk);
        end
        we = 1'b0;
        rd(4'h4, d); check("ovf status", d, 64'hD);
        rd(4'h4, d); check("ovf cleared", d, 64'h5);
        wait_cyc(k + 362);
        check_frame("ovf f2", k + 41, 8'h20, 4);
        check_frame("ovf f9", k + 321, 8'h27, 4);
        check("ovf busy end", 64'(busylog[k + 361]), 64'd0);
        check("ovf irq end", 64'(irqlog[k + 361]), 64'd1);
        check("ovf busy cycles", 64'(busy_total - bt), 64'd360);

        // Reset in DATA bit 3 of 0x55 with a second byte queued
        wr(4'h0, 64'h55);
        k = cyc;
        wr(4'h0, 64'h66);
        wait_cyc(k + 18);
        check("pre-rst bit3", 64'(tx), 64'd0);
        rst = 1'b0;
        #1;
        check("async rst tx", 64'(tx), 64'd1);
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst irq", 64'(irq), 64'd1);
        check("async rst rdata", rdata, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(4'h8, d); check("post-rst div", d, 64'd867);
        rd(4'h4, d); check("post-rst status", d, 64'h2);
        bt = busy_total;
        repeat (60) @(negedge clk);
        check("post-rst no frame", 64'(busy_total - bt), 64'd0);
        check("post-rst tx", 64'(tx), 64'd1);

        // DIV change mid-frame only affects the next frame
        wr(4'h8, 64'd1);
        wr(4'h0, 64'h07);
        k = cyc;
        @(negedge clk);
        wr(4'h8, 64'd5);
        wr(4'h0, 64'h0F);
        wait_cyc(k + 82);
        check_frame("div1", k + 1, 8'h07, 2);
        check_frame("div5", k + 21, 8'h0F, 6);
        check("div5 busy end", 64'(busylog[k + 81]), 64'd0);
        rd(4'h8, d); check("div readback", d, 64'd5);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
